video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 134 +++++++++++++
 tb/tb_video_timing_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with test-pattern pixel source.
// Ports:
//   clk, rst (async, active-low), en (run enable)
//   hTotal/hActive/hsWidth, vTotal/vActive/vsWidth : raster timing, latched per frame
//   patSel (0 bars, 1 ramp, 2 checker, 3 solid), solidColor
//   dOut/dOutEn/oHsyn/oVsyn : registered, mutually aligned video stream
//   cfgErr : latched timing configuration is invalid
// Optional feature macro: VIDEO_TIMING_GEN_CHECKER_EN builds the checkerboard pattern;
// without it patSel=2 falls back to the solid colour.
module video_timing_gen #(
   parameter int DATA_WIDTH      = 24,
   parameter int INPUT_RES_WIDTH = 11
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [INPUT_RES_WIDTH-1:0] hTotal,
   input  logic [INPUT_RES_WIDTH-1:0] hActive,
   input  logic [INPUT_RES_WIDTH-1:0] hsWidth,
   input  logic [INPUT_RES_WIDTH-1:0] vTotal,
   input  logic [INPUT_RES_WIDTH-1:0] vActive,
   input  logic [INPUT_RES_WIDTH-1:0] vsWidth,
   input  logic [1:0]                 patSel,
   input  logic [DATA_WIDTH-1:0]      solidColor,
   output logic [DATA_WIDTH-1:0]      dOut,
   output logic                       dOutEn,
   output logic                       oHsyn,
   output logic                       oVsyn,
   output logic                       cfgErr
);
   localparam int W = INPUT_RES_WIDTH;
   localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} stateT;

   stateT state, nextState;
   logic [W-1:0] hTot, hAct, hsW, vTot, vAct, vsW, barW;
   logic [W-1:0] hCnt, vCnt, barPix, hStart, vStart;
   logic [1:0] pat;
   logic [DATA_WIDTH-1:0] solid, pixel;
   logic [2:0] barIdx;
   logic [7:0] xLow;
   logic counting, hEnd, frameEnd, hIn, active, inValid, load, barLast;

   // Configuration is only taken from the inputs in IDLE or on the last cycle of a
   // frame; RUN and DRAIN behave identically at the frame boundary, so a DRAIN that
   // sees en again simply rolls into the next frame.
   always_comb begin
      nextState = state;
      load = 1'b0;
      if (state == IDLE || frameEnd) begin
         load = en;
         nextState = (en && inValid) ? RUN : IDLE;
      end else if (!en) begin
         nextState = DRAIN;
      end
   end

   always_comb begin
      counting = state != IDLE;
      hStart = hTot - hAct;
      vStart = vTot - vAct;
      hEnd = hCnt == hTot - W'(1);
      frameEnd = hEnd && vCnt == vTot - W'(1);
      hIn = hCnt >= hStart;
      active = counting && hIn && vCnt >= vStart;
      xLow = 8'(hCnt - hStart);
      barLast = barPix == barW - W'(1);
      inValid = hActive != '0 && vActive != '0 &&
                ({1'b0, hsWidth} + {1'b0, hActive} <= {1'b0, hTotal}) &&
                ({1'b0, vsWidth} + {1'b0, vActive} <= {1'b0, vTotal});
`ifdef VIDEO_TIMING_GEN_CHECKER_EN
      pixel = pat == 2'd0 ? BARS[barIdx] :
              pat == 2'd1 ? {3{xLow}} :
              pat == 2'd2 ? ((1'((hCnt - hStart) >> 4) ^ 1'((vCnt - vStart) >> 4)) ? '1 : '0) :
              solid;
`else
      pixel = pat == 2'd0 ? BARS[barIdx] : pat == 2'd1 ? {3{xLow}} : solid;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         hTot   <= '0;
         hAct   <= '0;
         hsW    <= '0;
         vTot   <= '0;
         vAct   <= '0;
         vsW    <= '0;
         barW   <= '0;
         pat    <= '0;
         solid  <= '0;
         hCnt   <= '0;
         vCnt   <= '0;
         barPix <= '0;
         barIdx <= '0;
         dOut   <= '0;
         dOutEn <= 1'b0;
         oHsyn  <= 1'b0;
         oVsyn  <= 1'b0;
         cfgErr <= 1'b0;
      end else begin
         state <= nextState;
         if (load) begin
            hTot   <= hTotal;
            hAct   <= hActive;
            hsW    <= hsWidth;
            vTot   <= vTotal;
            vAct   <= vActive;
            vsW    <= vsWidth;
            barW   <= hActive < W'(8) ? W'(1) : hActive >> 3;
            pat    <= patSel;
            solid  <= solidColor;
            cfgErr <= !inValid;
         end
         hCnt <= (!counting || hEnd) ? '0 : hCnt + W'(1);
         vCnt <= (!counting || frameEnd) ? '0 : hEnd ? vCnt + W'(1) : vCnt;
         // Bar position tracked incrementally per line to avoid a divider.
         if (!counting || hEnd) begin
            barPix <= '0;
            barIdx <= '0;
         end else if (hIn) begin
            barPix <= barLast ? '0 : barPix + W'(1);
            barIdx <= (barLast && barIdx != 3'd7) ? barIdx + 3'd1 : barIdx;
         end
         dOutEn <= active;
         dOut   <= active ? pixel : '0;
         oHsyn  <= counting && hCnt < hsW;
         oVsyn  <= counting && vCnt < vsW;
      end
   end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized and directed checks of video_timing_gen against a frame-level model.
module tb_video_timing_gen;
   localparam int W = 11;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en = 1'b0;
   logic [W-1:0] hTotal, hActive, hsWidth, vTotal, vActive, vsWidth;
   logic [1:0] patSel;
   logic [23:0] solidColor;
   logic [23:0] dOut;
   logic dOutEn, oHsyn, oVsyn, cfgErr;

   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Reference model: a running flag, the cycle index within the frame and the latched config.
   bit mRun = 0;
   bit mErr = 0;
   int mT = 0;
   int cH = 0, cHA = 0, cHS = 0, cV = 0, cVA = 0, cVS = 0, cPat = 0;
   logic [23:0] cSol = '0;

   always #5 clk = ~clk;

   video_timing_gen #(.DATA_WIDTH(24), .INPUT_RES_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .en(en),
      .hTotal(hTotal), .hActive(hActive), .hsWidth(hsWidth),
      .vTotal(vTotal), .vActive(vActive), .vsWidth(vsWidth),
      .patSel(patSel), .solidColor(solidColor),
      .dOut(dOut), .dOutEn(dOutEn), .oHsyn(oHsyn), .oVsyn(oVsyn), .cfgErr(cfgErr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [26:0] pixPart();
      int h, v, x, y, bw, idx;
      bit on;
      logic [23:0] px;
      logic [7:0] r;
      if (!mRun) return '0;
      h = mT % cH;
      v = mT / cH;
      on = h >= cH - cHA && v >= cV - cVA;
      x = h - (cH - cHA);
      y = v - (cV - cVA);
      bw = cHA / 8 == 0 ? 1 : cHA / 8;
      idx = x / bw > 7 ? 7 : x / bw;
      r = 8'(x % 256);
      case (cPat)
         0: px = bars[idx];
         1: px = {r, r, r};
`ifdef VIDEO_TIMING_GEN_CHECKER_EN
         2: px = ((x / 16) % 2 != (y / 16) % 2) ? 24'hFFFFFF : 24'h000000;
`else
         2: px = cSol;
`endif
         default: px = cSol;
      endcase
      return {on ? px : 24'h0, on, h < cHS, v < cVS};
   endfunction

   task automatic modelEdge();
      bit ok;
      if (!rst) begin
         mRun = 0; mErr = 0; mT = 0;
         cH = 0; cHA = 0; cHS = 0; cV = 0; cVA = 0; cVS = 0; cPat = 0; cSol = '0;
         return;
      end
      if (!mRun || mT == cH * cV - 1) begin
         mT = 0;
         if (en) begin
            cH = int'(hTotal); cHA = int'(hActive); cHS = int'(hsWidth);
            cV = int'(vTotal); cVA = int'(vActive); cVS = int'(vsWidth);
            cPat = int'(patSel); cSol = solidColor;
            ok = cHA != 0 && cVA != 0 && cHS + cHA <= cH && cVS + cVA <= cV;
            mErr = !ok;
            mRun = ok;
         end else begin
            mRun = 0;
         end
      end else begin
         mT++;
      end
   endtask

   task automatic tick();
      logic [26:0] p;
      p = rst ? pixPart() : '0;
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      cyc++;
      check($sformatf("outs@%0d", cyc), {dOut, dOutEn, oHsyn, oVsyn, cfgErr}, {p, mErr});
   endtask

   task automatic setCfg(input int hT, input int hA, input int hs, input int vT, input int vA, input int vs);
      hTotal = 11'(hT); hActive = 11'(hA); hsWidth = 11'(hs);
      vTotal = 11'(vT); vActive = 11'(vA); vsWidth = 11'(vs);
   endtask

   task automatic randCfg();
      int hT, hA, hs, vT, vA, vs;
      hT = $urandom_range(40, 4);
      hA = $urandom_range(hT, 1);
      hs = $urandom_range(hT - hA, 0);
      vT = $urandom_range(10, 2);
      vA = $urandom_range(vT, 1);
      vs = $urandom_range(vT - vA, 0);
      if ($urandom_range(4, 0) == 0) hs = hT - hA + 1;
      setCfg(hT, hA, hs, vT, vA, vs);
      patSel = 2'($urandom_range(3, 0));
      solidColor = 24'($urandom);
   endtask

   initial begin
      int cntEn, cntH, cntV;
      logic [23:0] pix [$];
      setCfg(16, 8, 2, 6, 4, 1);
      patSel = 2'd0;
      solidColor = 24'h123456;
      repeat (3) tick();
      check("reset_outs", {dOut, dOutEn, oHsyn, oVsyn, cfgErr}, 0);
      rst = 1'b1;
      repeat (4) tick();
      check("idle_quiet", {dOut, dOutEn, oHsyn, oVsyn, cfgErr}, 0);

      // Base timing: three whole frames of counts and bar order.
      en = 1'b1;
      tick();
      cntEn = 0; cntH = 0; cntV = 0;
      repeat (288) begin
         tick();
         cntEn += int'(dOutEn);
         cntH += int'(oHsyn);
         cntV += int'(oVsyn);
         if (dOutEn) pix.push_back(dOut);
      end
      check("den_cnt", cntEn, 96);
      check("hsyn_cnt", cntH, 36);
      check("vsyn_cnt", cntV, 48);
      check("pix_cnt", pix.size(), 96);
      for (int i = 0; i < 16 && i < pix.size(); i++) check($sformatf("bar%0d", i), pix[i], bars[i % 8]);

      // Drop en part-way through a frame; the frame must finish, then stay quiet.
      repeat (40) tick();
      en = 1'b0;
      repeat (70) tick();
      check("drain_idle", {dOut, dOutEn, oHsyn, oVsyn, cfgErr}, 0);
      en = 1'b1;
      tick();
      tick();
      check("restart_sync", {oHsyn, oVsyn}, 2'b11);

      // Invalid H-sync width, then corrected.
      en = 1'b0;
      repeat (100) tick();
      hsWidth = 11'd9;
      en = 1'b1;
      repeat (3) tick();
      check("cfg_err_on", cfgErr, 1);
      check("cfg_err_noden", dOutEn, 0);
      hsWidth = 11'd2;
      tick();
      check("cfg_err_off", cfgErr, 0);

      // Mid-frame hActive change only affects the next frame.
      repeat (30) tick();
      hActive = 11'd4;
      repeat (200) tick();

      // Checker/solid pattern on a frame large enough to toggle both axes.
      en = 1'b0;
      repeat (200) tick();
      setCfg(48, 36, 4, 40, 36, 2);
      patSel = 2'd2;
      solidColor = 24'hA5C3E1;
      en = 1'b1;
      repeat (1940) tick();

      // Ramp wrap past 256 pixels.
      setCfg(300, 280, 8, 2, 1, 1);
      patSel = 2'd1;
      repeat (2000) tick();

      // Randomized configurations with en toggling and mid-frame input changes.
      for (int it = 0; it < 12; it++) begin
         randCfg();
         en = 1'b1;
         repeat (250) begin
            if ($urandom_range(99, 0) < 3) en = ~en;
            if ($urandom_range(99, 0) < 2) randCfg();
            tick();
         end
      end

      // Asynchronous reset while pixels are active.
      en = 1'b0;
      repeat (400) tick();
      setCfg(16, 8, 2, 6, 4, 1);
      patSel = 2'd3;
      en = 1'b1;
      for (int i = 0; i < 300 && !dOutEn; i++) tick();
      check("wait_active", dOutEn, 1);
      #2 rst = 1'b0;
      #1 check("async_rst", {dOut, dOutEn, oHsyn, oVsyn, cfgErr}, 0);
      tick();
      tick();
      rst = 1'b1;
      repeat (120) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
